// File: rtl/lsu_nd.sv
// Load/store unit for a CGRA tile: looping instruction buffer, 2-D affine AGU,
// back-pressure stall and registered load return to the PE.
module lsu_nd #(
  parameter  int DW    = 32,
  parameter  int AW    = 16,
  parameter  int DEPTH = 16,
  parameter  int SELW  = 3,
  parameter  int CNTW  = 16,
  localparam int IW    = 3*SELW+3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic [IW-1:0]   cfg_inst,
  input  logic            agu_we,
  input  logic [2:0]      agu_waddr,
  input  logic [AW-1:0]   agu_wdata,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   pe_in,
  output logic            ren,
  output logic [SELW-1:0] r_sel,
  output logic            wen,
  output logic [SELW-1:0] w_sel,
  output logic [DW-1:0]   wdata,
  output logic [AW-1:0]   addr,
  output logic [SELW-1:0] addr_sel,
  output logic [DW-1:0]   lsu_to_pe,
  output logic            lsu_to_pe_valid,
  output logic            done,
  output logic            cfg_full
);
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0]   r_buf [DEPTH];
  logic [PW:0]     r_init_ptr;
  logic [PW-1:0]   r_run_ptr;
  logic [IW-1:0]   r_inst;
  logic [AW-1:0]   r_base, r_stride0, r_stride1;
  logic [CNTW-1:0] r_bound0, r_bound1;
  logic [CNTW-1:0] r_i, r_j;
  logic [AW-1:0]   r_acc_i, r_acc_j;
  logic [DW-1:0]   r_load, r_store;
  logic            r_load_vld;
  logic            r_done;

  logic            w_stall, w_adv, w_store_sel;
  logic [PW:0]     w_run_inc;
  logic [CNTW-1:0] w_b0_last, w_b1_last;

  assign ren         = r_inst[IW-1];
  assign wen         = r_inst[IW-2];
  assign r_sel       = r_inst[IW-3 -: SELW];
  assign w_sel       = r_inst[IW-3-SELW -: SELW];
  assign addr_sel    = r_inst[SELW:1];
  assign w_store_sel = r_inst[0];

  assign w_stall   = (ren | wen) & ~mem_ready;
  assign w_adv     = (ren | wen) & mem_ready;
  assign cfg_full  = (r_init_ptr == (PW+1)'(DEPTH));
  assign w_run_inc = (PW+1)'(r_run_ptr) + (PW+1)'(1);

  // A programmed bound of 0 behaves as 1, so the last index is 0 either way.
  assign w_b0_last = (r_bound0 == '0) ? '0 : r_bound0 - CNTW'(1);
  assign w_b1_last = (r_bound1 == '0) ? '0 : r_bound1 - CNTW'(1);

  assign addr            = r_base + r_acc_i + r_acc_j;
  assign wdata           = r_store;
  assign lsu_to_pe       = r_load;
  assign lsu_to_pe_valid = r_load_vld;
  assign done            = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_buf[k] <= '0;
      r_init_ptr <= '0;
    end else if (init && !cfg_full) begin
      r_buf[r_init_ptr[PW-1:0]] <= cfg_inst;
      r_init_ptr                <= r_init_ptr + (PW+1)'(1);
    end
  end

  // init owns the cycle; run only steps when no request is being held off.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst    <= '0;
      r_run_ptr <= '0;
    end else if (!init && run && !w_stall) begin
      if (r_init_ptr == '0) begin
        r_inst <= '0;
      end else begin
        r_inst    <= r_buf[r_run_ptr];
        r_run_ptr <= (w_run_inc == r_init_ptr) ? '0 : w_run_inc[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base    <= '0;
      r_stride0 <= '0;
      r_stride1 <= '0;
      r_bound0  <= '0;
      r_bound1  <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_acc_i   <= '0;
      r_acc_j   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (agu_we) begin
        case (agu_waddr)
          3'd0:    r_base    <= agu_wdata;
          3'd1:    r_stride0 <= agu_wdata;
          3'd2:    r_stride1 <= agu_wdata;
          3'd3:    r_bound0  <= CNTW'(agu_wdata);
          3'd4:    r_bound1  <= CNTW'(agu_wdata);
          default: ;
        endcase
        r_i     <= '0;
        r_j     <= '0;
        r_acc_i <= '0;
        r_acc_j <= '0;
      end else if (w_adv) begin
        if (r_j < w_b0_last) begin
          r_j     <= r_j + CNTW'(1);
          r_acc_j <= r_acc_j + r_stride0;
        end else begin
          r_j     <= '0;
          r_acc_j <= '0;
          if (r_i < w_b1_last) begin
            r_i     <= r_i + CNTW'(1);
            r_acc_i <= r_acc_i + r_stride1;
          end else begin
            r_i     <= '0;
            r_acc_i <= '0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load     <= '0;
      r_load_vld <= 1'b0;
      r_store    <= '0;
    end else begin
      r_load_vld <= mem_rvalid;
      if (mem_rvalid) r_load <= mem_rdata;
      if (!w_stall) r_store <= w_store_sel ? r_load : pe_in;
    end
  end

endmodule

// File: tb/tb_lsu_nd.sv
// Scoreboard bench for lsu_nd: a queue-based program model and a flat sweep
// index for the AGU predict every cycle's outputs; a monitor pops and compares.
module tb_lsu_nd;
  localparam int DW = 32, AW = 16, DEPTH = 16, SELW = 3, CNTW = 16, IW = 12;

  logic            clk = 1'b0;
  logic            rst, init, agu_we, run, mem_ready, mem_rvalid;
  logic [IW-1:0]   cfg_inst;
  logic [2:0]      agu_waddr;
  logic [AW-1:0]   agu_wdata;
  logic [DW-1:0]   mem_rdata, pe_in;
  logic            ren, wen, lsu_to_pe_valid, done, cfg_full;
  logic [SELW-1:0] r_sel, w_sel, addr_sel;
  logic [DW-1:0]   wdata, lsu_to_pe;
  logic [AW-1:0]   addr;

  lsu_nd #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .SELW(SELW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .init(init), .cfg_inst(cfg_inst), .agu_we(agu_we),
    .agu_waddr(agu_waddr), .agu_wdata(agu_wdata), .run(run), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pe_in(pe_in),
    .ren(ren), .r_sel(r_sel), .wen(wen), .w_sel(w_sel), .wdata(wdata),
    .addr(addr), .addr_sel(addr_sel), .lsu_to_pe(lsu_to_pe),
    .lsu_to_pe_valid(lsu_to_pe_valid), .done(done), .cfg_full(cfg_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ren, wen, lv, done, full;
    logic [2:0]    rs, ws, as;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, lpe;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] lq[$];
  int            n_vec = 0, n_err = 0;

  // Reference model state
  logic [IW-1:0] m_prog[$];
  int            m_pc;
  logic [IW-1:0] m_cur;
  logic [AW-1:0] m_base, m_s0, m_s1;
  longint        m_b0, m_b1, m_k;
  logic [DW-1:0] m_load, m_store;
  logic          m_lv, m_done;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prog.delete();
    m_pc = 0; m_cur = '0; m_base = '0; m_s0 = '0; m_s1 = '0;
    m_b0 = 0; m_b1 = 0; m_k = 0; m_load = '0; m_store = '0; m_lv = 0; m_done = 0;
  endtask

  // Applies the current inputs to the model and queues the post-edge outputs.
  task automatic tick();
    exp_t   e;
    logic   req, stall, acc;
    longint b0e, b1e;
    req   = m_cur[IW-1] | m_cur[IW-2];
    stall = req & ~mem_ready;
    acc   = req & mem_ready;
    if (rst) begin
      model_reset();
    end else begin
      if (!stall) m_store = m_cur[0] ? m_load : pe_in;
      if (mem_rvalid) begin
        m_load = mem_rdata;
        lq.push_back(mem_rdata);
      end
      m_lv   = mem_rvalid;
      m_done = 1'b0;
      if (agu_we) begin
        case (agu_waddr)
          3'd0: m_base = agu_wdata;
          3'd1: m_s0   = agu_wdata;
          3'd2: m_s1   = agu_wdata;
          3'd3: m_b0   = longint'(agu_wdata);
          3'd4: m_b1   = longint'(agu_wdata);
          default: ;
        endcase
        m_k = 0;
      end else if (acc) begin
        b0e = (m_b0 == 0) ? 1 : m_b0;
        b1e = (m_b1 == 0) ? 1 : m_b1;
        if (m_k + 1 == b0e * b1e) begin
          m_k    = 0;
          m_done = 1'b1;
        end else begin
          m_k++;
        end
      end
      if (init) begin
        if (m_prog.size() < DEPTH) m_prog.push_back(cfg_inst);
      end else if (run && !stall) begin
        if (m_prog.size() == 0) m_cur = '0;
        else begin
          m_cur = m_prog[m_pc];
          m_pc  = (m_pc + 1) % m_prog.size();
        end
      end
    end
    b0e     = (m_b0 == 0) ? 1 : m_b0;
    e.ren   = m_cur[11];
    e.wen   = m_cur[10];
    e.rs    = m_cur[9:7];
    e.ws    = m_cur[6:4];
    e.as    = m_cur[3:1];
    e.addr  = AW'(longint'(m_base) + (m_k % b0e) * longint'(m_s0) + (m_k / b0e) * longint'(m_s1));
    e.wdata = m_store;
    e.lpe   = m_load;
    e.lv    = m_lv;
    e.done  = m_done;
    e.full  = (m_prog.size() == DEPTH);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; init = 0; agu_we = 0; run = 0; mem_ready = 1; mem_rvalid = 0;
    cfg_inst = '0; agu_waddr = '0; agu_wdata = '0; mem_rdata = '0; pe_in = '0;
  endtask

  task automatic do_init(input logic [IW-1:0] inst);
    idle(); init = 1; cfg_inst = inst; tick();
  endtask

  task automatic agu_wr(input logic [2:0] a, input logic [AW-1:0] d);
    idle(); agu_we = 1; agu_waddr = a; agu_wdata = d; tick();
  endtask

  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin idle(); rst = 1; tick(); end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ren", DW'(ren), DW'(e.ren));
        chk("wen", DW'(wen), DW'(e.wen));
        chk("r_sel", DW'(r_sel), DW'(e.rs));
        chk("w_sel", DW'(w_sel), DW'(e.ws));
        chk("addr_sel", DW'(addr_sel), DW'(e.as));
        chk("addr", DW'(addr), DW'(e.addr));
        chk("wdata", wdata, e.wdata);
        chk("lsu_to_pe", lsu_to_pe, e.lpe);
        chk("lsu_to_pe_valid", DW'(lsu_to_pe_valid), DW'(e.lv));
        chk("done", DW'(done), DW'(e.done));
        chk("cfg_full", DW'(cfg_full), DW'(e.full));
      end
      if (lsu_to_pe_valid === 1'b1) begin
        if (lq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL load_return: valid with no load outstanding at %0t", $time);
        end else begin
          chk("load_return", lsu_to_pe, lq.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: stimulus did not complete, %0d scoreboard entries left", sb.size());
    $fatal(1, "timeout");
  end

  localparam logic [IW-1:0] I0 = 12'b1_0_001_000_010_0;  // load
  localparam logic [IW-1:0] I1 = 12'b0_1_000_011_101_1;  // store of load_reg
  localparam logic [IW-1:0] I2 = 12'b0_0_000_000_000_0;  // nop

  initial begin : stim
    idle();
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Looping program, then fill the buffer and attempt one more write
    do_init(I0); do_init(I1); do_init(I2);
    for (int c = 0; c < 7; c++) begin idle(); run = 1; pe_in = $urandom; tick(); end
    for (int c = 3; c < DEPTH; c++) do_init(IW'($urandom));
    do_init(12'hFFF);
    for (int c = 0; c < 20; c++) begin idle(); run = 1; pe_in = $urandom; tick(); end

    // 2-D sweep with a stall in the middle
    do_reset(1);
    agu_wr(0, 16'h0100); agu_wr(1, 16'h0001); agu_wr(2, 16'h0040);
    agu_wr(3, 16'd3);    agu_wr(4, 16'd2);
    do_init(I0); do_init(I1);
    idle(); run = 1; tick();
    for (int c = 0; c < 7; c++) begin idle(); pe_in = $urandom; tick(); end
    for (int c = 0; c < 10; c++) begin
      idle(); run = 1; pe_in = $urandom; mem_ready = !(c >= 3 && c < 7); tick();
    end

    // Degenerate bounds: every accepted request is the last one
    agu_wr(3, 16'd0); agu_wr(4, 16'd0); agu_wr(2, 16'd5);
    for (int c = 0; c < 6; c++) begin idle(); run = 1; tick(); end

    // Load return feeding a store
    do_reset(1);
    do_init(I1);
    idle(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; tick();
    idle(); run = 1; pe_in = 32'h12345678; tick();
    for (int c = 0; c < 3; c++) begin idle(); pe_in = 32'h0BADF00D; tick(); end

    // Reset in the middle of a sweep
    agu_wr(0, 16'h0200); agu_wr(3, 16'd4);
    do_init(I0);
    for (int c = 0; c < 3; c++) begin idle(); run = 1; tick(); end
    do_reset(1);
    for (int c = 0; c < 2; c++) begin idle(); run = 1; tick(); end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst        = ($urandom_range(0, 199) == 0);
      init       = ($urandom_range(0, 7) == 0);
      cfg_inst   = IW'($urandom);
      agu_we     = ($urandom_range(0, 19) == 0);
      agu_waddr  = 3'($urandom_range(0, 7));
      agu_wdata  = (agu_waddr == 3 || agu_waddr == 4) ? AW'($urandom_range(0, 4)) : AW'($urandom);
      run        = ($urandom_range(0, 1) == 1);
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      pe_in      = $urandom;
      tick();
    end

    idle();
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", DW'(sb.size()), '0);
    chk("lq_drained", DW'(lq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
